// File: rtl/shifter_left_sequential.sv
// Multi-cycle left shifter: one bit per clock, with a fast path for zero shifts
// and for shifts of WIDTH or more. One request is in flight at a time.
module shifter_left_sequential #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SHIFT_WIDTH = 4,
    parameter logic [0:0]  PAD_VALUE   = 1'b0
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   input_valid,
    output logic                   input_ready,
    input  logic [WIDTH-1:0]       input_data,
    input  logic [SHIFT_WIDTH-1:0] input_shift,
    output logic                   output_valid,
    input  logic                   output_ready,
    output logic [WIDTH-1:0]       output_data,
    output logic                   busy
);

    // Sized from WIDTH only, so it always holds WIDTH-1 whatever SHIFT_WIDTH is.
    localparam int unsigned COUNT_WIDTH = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StShifting,
        StDone
    } state_t;

    state_t                 state_q;
    logic [WIDTH-1:0]       data_q;
    logic [COUNT_WIDTH-1:0] count_q;
    logic [31:0]            shift_ext;

    assign shift_ext = 32'(input_shift);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (input_valid) begin
                        if (shift_ext == 32'd0) begin
                            data_q  <= input_data;
                            state_q <= StDone;
                        end else if (shift_ext >= WIDTH) begin
                            data_q  <= {WIDTH{PAD_VALUE[0]}};
                            state_q <= StDone;
                        end else begin
                            data_q  <= input_data;
                            count_q <= COUNT_WIDTH'(shift_ext);
                            state_q <= StShifting;
                        end
                    end
                end
                StShifting: begin
                    data_q  <= {data_q[WIDTH-2:0], PAD_VALUE[0]};
                    count_q <= count_q - COUNT_WIDTH'(1);
                    if (count_q == COUNT_WIDTH'(1)) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    if (output_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign input_ready  = (state_q == StIdle);
    assign output_valid = (state_q == StDone);
    assign busy         = (state_q != StIdle);
    assign output_data  = data_q;

endmodule

// File: tb/tb_shifter_left_sequential.sv
// Directed bench: two instances (PAD_VALUE 0 and 1) share one stimulus stream.
module tb_shifter_left_sequential;

    logic       clock = 1'b0;
    logic       resetn;
    logic       input_valid;
    logic [7:0] input_data;
    logic [3:0] input_shift;
    logic       output_ready;

    logic       ready0, valid0, busy0;
    logic       ready1, valid1, busy1;
    logic [7:0] data0, data1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    shifter_left_sequential #(
        .WIDTH(8), .SHIFT_WIDTH(4), .PAD_VALUE(1'b0)
    ) u_dut_pad0 (
        .clock(clock), .resetn(resetn),
        .input_valid(input_valid), .input_ready(ready0),
        .input_data(input_data), .input_shift(input_shift),
        .output_valid(valid0), .output_ready(output_ready),
        .output_data(data0), .busy(busy0)
    );

    shifter_left_sequential #(
        .WIDTH(8), .SHIFT_WIDTH(4), .PAD_VALUE(1'b1)
    ) u_dut_pad1 (
        .clock(clock), .resetn(resetn),
        .input_valid(input_valid), .input_ready(ready1),
        .input_data(input_data), .input_shift(input_shift),
        .output_valid(valid1), .output_ready(output_ready),
        .output_data(data1), .busy(busy1)
    );

    // Present one request, let it be accepted, then count edges until output_valid.
    // Returns with the bench sitting on the negedge where output_valid is first seen.
    task automatic send(input logic [7:0] d, input logic [3:0] s, output int lat);
        @(negedge clock);
        input_valid = 1'b1;
        input_data  = d;
        input_shift = s;
        @(posedge clock);
        @(negedge clock);
        input_valid = 1'b0;
        input_data  = 8'h00;
        input_shift = 4'h0;
        lat = 0;
        while (!valid0 && lat < 20) begin
            @(negedge clock);
            lat++;
        end
    endtask

    task automatic finish_handshake();
        output_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        output_ready = 1'b0;
    endtask

    task automatic test_reset();
        resetn       = 1'b0;
        input_valid  = 1'b0;
        input_data   = 8'h00;
        input_shift  = 4'h0;
        output_ready = 1'b0;
        repeat (3) @(negedge clock);
        vectors++;
        if ({ready0, valid0, busy0, data0} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
            miscompares++;
            $display("FAIL reset_pad0: got rdy/vld/busy/data=%b%b%b %h, want 100 00",
                     ready0, valid0, busy0, data0);
        end
        vectors++;
        if ({ready1, valid1, busy1, data1} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
            miscompares++;
            $display("FAIL reset_pad1: got rdy/vld/busy/data=%b%b%b %h, want 100 00",
                     ready1, valid1, busy1, data1);
        end
        resetn = 1'b1;
    endtask

    task automatic test_basic();
        int lat;
        send(8'b1011_0011, 4'd3, lat);
        vectors++;
        if (lat !== 3) begin
            miscompares++;
            $display("FAIL basic_latency: got %0d edges, want 3", lat);
        end
        vectors++;
        if (data0 !== 8'b1001_1000) begin
            miscompares++;
            $display("FAIL basic_pad0: got %h, want 98", data0);
        end
        vectors++;
        if (data1 !== 8'b1001_1111) begin
            miscompares++;
            $display("FAIL basic_pad1: got %h, want 9f", data1);
        end
        finish_handshake();
        vectors++;
        if ({ready0, valid0, busy0} !== 3'b100) begin
            miscompares++;
            $display("FAIL basic_idle: got rdy/vld/busy=%b%b%b, want 100", ready0, valid0, busy0);
        end
    endtask

    task automatic test_zero_and_saturate();
        int lat;
        send(8'h0F, 4'd0, lat);
        vectors++;
        if (lat !== 0 || data0 !== 8'h0F || data1 !== 8'h0F) begin
            miscompares++;
            $display("FAIL shift0: got lat=%0d pad0=%h pad1=%h, want lat=0 0f 0f", lat, data0, data1);
        end
        finish_handshake();
        send(8'h0F, 4'd9, lat);
        vectors++;
        if (lat !== 0 || data0 !== 8'h00 || data1 !== 8'hFF) begin
            miscompares++;
            $display("FAIL shift9: got lat=%0d pad0=%h pad1=%h, want lat=0 00 ff", lat, data0, data1);
        end
        finish_handshake();
        send(8'hC3, 4'd8, lat);
        vectors++;
        if (lat !== 0 || data0 !== 8'h00 || data1 !== 8'hFF) begin
            miscompares++;
            $display("FAIL shift8: got lat=%0d pad0=%h pad1=%h, want lat=0 00 ff", lat, data0, data1);
        end
        finish_handshake();
    endtask

    task automatic test_backpressure();
        int lat;
        send(8'hA5, 4'd2, lat);
        // Competing request while held in DONE must be dropped, not queued.
        input_valid = 1'b1;
        input_data  = 8'h3C;
        input_shift = 4'd1;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if ({valid0, ready0, busy0, data0, data1} !== {3'b101, 8'h94, 8'h97}) begin
                miscompares++;
                $display("FAIL backpressure_hold%0d: got vld/rdy/busy=%b%b%b %h %h, want 101 94 97",
                         i, valid0, ready0, busy0, data0, data1);
            end
            @(negedge clock);
        end
        input_valid = 1'b0;
        finish_handshake();
        repeat (3) begin
            vectors++;
            if ({ready0, valid0, busy0} !== 3'b100) begin
                miscompares++;
                $display("FAIL backpressure_dropped: got rdy/vld/busy=%b%b%b, want 100",
                         ready0, valid0, busy0);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_reset_mid();
        bit seen_valid = 1'b0;
        @(negedge clock);
        input_valid = 1'b1;
        input_data  = 8'hFF;
        input_shift = 4'd7;
        @(posedge clock);
        @(negedge clock);
        input_valid = 1'b0;
        repeat (3) @(negedge clock);  // three shifting edges: count 7 -> 4
        vectors++;
        if (busy0 !== 1'b1 || valid0 !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_pre: got busy=%b vld=%b, want 1 0", busy0, valid0);
        end
        #2 resetn = 1'b0;
        #1;
        vectors++;
        if ({ready0, valid0, busy0, data0, data1} !== {3'b100, 8'h00, 8'h00}) begin
            miscompares++;
            $display("FAIL midreset_async: got rdy/vld/busy=%b%b%b %h %h, want 100 00 00",
                     ready0, valid0, busy0, data0, data1);
        end
        @(negedge clock);
        resetn = 1'b1;
        repeat (10) begin
            @(negedge clock);
            if (valid0 || valid1) seen_valid = 1'b1;
        end
        vectors++;
        if (seen_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_no_result: got output_valid seen=%b, want 0", seen_valid);
        end
    endtask

    task automatic test_exhaustive();
        for (int s = 0; s < 16; s++) begin
            logic [7:0] d, exp0, exp1;
            int lat, exp_lat, tries;
            bit done;
            d = 8'($urandom);
            if (s >= 8) begin
                exp0 = 8'h00;
                exp1 = 8'hFF;
            end else begin
                exp0 = d << s;
                exp1 = (d << s) | ~(8'hFF << s);
            end
            exp_lat = (s == 0 || s >= 8) ? 0 : s;
            output_ready = 1'($urandom_range(0, 1));  // ignored outside DONE
            send(d, 4'(s), lat);
            vectors++;
            if (lat !== exp_lat) begin
                miscompares++;
                $display("FAIL exh_latency s=%0d: got %0d, want %0d", s, lat, exp_lat);
            end
            done  = 1'b0;
            tries = 0;
            while (!done) begin
                vectors++;
                if (valid0 !== 1'b1 || data0 !== exp0 || data1 !== exp1) begin
                    miscompares++;
                    $display("FAIL exh_result s=%0d d=%h: got vld=%b %h %h, want 1 %h %h",
                             s, d, valid0, data0, data1, exp0, exp1);
                end
                output_ready = (tries >= 4) ? 1'b1 : 1'($urandom_range(0, 1));
                tries++;
                done = output_ready;
                @(negedge clock);
            end
            output_ready = 1'b0;
            vectors++;
            if (ready0 !== 1'b1 || valid0 !== 1'b0) begin
                miscompares++;
                $display("FAIL exh_idle s=%0d: got rdy=%b vld=%b, want 1 0", s, ready0, valid0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_and_saturate();
        test_backpressure();
        test_reset_mid();
        test_exhaustive();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded bound");
        $fatal(1);
    end

endmodule
